// File: rtl/x2_seq_decoder.sv
// x2_seq_decoder: buffered, registered select/qualifier decoder.
//
// Commands {sel, qual} are accepted over a valid/ready handshake into a DEPTH-entry FIFO.
// Each command is popped into a command register, decoded into a one-hot strobe, held for
// HOLD_CYC cycles and then presented with its own valid/ready handshake.
//
// Optional feature macro: X2_SEQ_BYPASS_EN. When it is defined, a command that arrives
// while the block is idle and the FIFO is empty goes straight into the command register,
// which saves one cycle of latency.
//
// Ports:
//   clk_pad        in   clock, rising edge
//   rst_pad        in   synchronous active-high reset
//   in_valid_pad   in   command valid
//   in_ready_pad   out  FIFO can accept (from registered occupancy only)
//   sel_pad        in   command select
//   qual_pad       in   command qualifiers (bit 0 enable, bit 1 fault-arm)
//   out_valid_pad  out  decoded result presented
//   out_ready_pad  in   consumer accepts result
//   strobe_pad     out  one-hot decode of sel, gated by enable
//   suppressed_pad out  current command has enable low
//   fault_pad      out  sel all-ones with fault-arm set
//   busy_pad       out  a command is held or presented
//   count_pad      out  FIFO occupancy
module x2_seq_decoder #(
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned QUAL_W   = 7,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic                       clk_pad,
   input  logic                       rst_pad,
   input  logic                       in_valid_pad,
   output logic                       in_ready_pad,
   input  logic [SEL_W-1:0]           sel_pad,
   input  logic [QUAL_W-1:0]          qual_pad,
   output logic                       out_valid_pad,
   input  logic                       out_ready_pad,
   output logic [(1<<SEL_W)-1:0]      strobe_pad,
   output logic                       suppressed_pad,
   output logic                       fault_pad,
   output logic                       busy_pad,
   output logic [$clog2(DEPTH+1)-1:0] count_pad
);

   localparam int unsigned STB_W  = 1 << SEL_W;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HCNT_W-1:0] HoldLoad = (HOLD_CYC == 0) ? '0 : HCNT_W'(HOLD_CYC - 1);

   typedef enum logic [1:0] {StIdle, StHold, StPresent} state_e;

   // Only enable and fault-arm affect the decode, so only those two bits are stored.
   logic unused_qual_hi;
   if (QUAL_W > 2) begin : g_qual_hi
      assign unused_qual_hi = ^qual_pad[QUAL_W-1:2];
   end else begin : g_no_qual_hi
      assign unused_qual_hi = 1'b0;
   end

   // FIFO storage and pointers
   logic [SEL_W-1:0] mem_sel_q  [DEPTH];
   logic [1:0]       mem_qual_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Sequencer state and registered outputs
   state_e              state_q, state_d;
   logic [HCNT_W-1:0]   hold_q, hold_d;
   logic [SEL_W-1:0]    cmd_sel_q, cmd_sel_d;
   logic [1:0]          cmd_qual_q, cmd_qual_d;
   logic [STB_W-1:0]    strobe_q, strobe_d;
   logic                suppressed_q, suppressed_d;
   logic                fault_q, fault_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;

   logic fifo_empty;
   logic accept;
   logic push;
   logic pop;
   logic load;
   logic bypass;
   logic [SEL_W-1:0] src_sel;
   logic [1:0]       src_qual;

   assign fifo_empty   = (count_q == '0);
   assign in_ready_pad = (count_q < CNT_W'(DEPTH));
   assign accept       = in_valid_pad & in_ready_pad;
   assign push         = accept & ~bypass;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      pop      = 1'b0;
      load     = 1'b0;
      bypass   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop  = 1'b1;
               load = 1'b1;
            end
`ifdef X2_SEQ_BYPASS_EN
            else if (accept) begin
               bypass = 1'b1;
               load   = 1'b1;
            end
`endif
         end
         StHold: begin
            if (hold_q == '0) begin
               state_d = StPresent;
            end else begin
               hold_d = hold_q - HCNT_W'(1);
            end
         end
         StPresent: begin
            if (out_ready_pad) begin
               if (!fifo_empty) begin
                  // Chain straight into the next command, no idle bubble.
                  pop  = 1'b1;
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      src_sel  = bypass ? sel_pad      : mem_sel_q[rd_ptr_q];
      src_qual = bypass ? qual_pad[1:0] : mem_qual_q[rd_ptr_q];

      cmd_sel_d  = cmd_sel_q;
      cmd_qual_d = cmd_qual_q;
      if (load) begin
         cmd_sel_d  = src_sel;
         cmd_qual_d = src_qual;
         hold_d     = HoldLoad;
         state_d    = (HOLD_CYC == 0) ? StPresent : StHold;
      end

      // Outputs are registered from the next command/state so they change on the same edge.
      busy_d       = (state_d != StIdle);
      out_valid_d  = (state_d == StPresent);
      strobe_d     = '0;
      suppressed_d = 1'b0;
      fault_d      = 1'b0;
      if (busy_d) begin
         strobe_d     = {{(STB_W-1){1'b0}}, cmd_qual_d[0]} << cmd_sel_d;
         suppressed_d = ~cmd_qual_d[0];
         fault_d      = (&cmd_sel_d) & cmd_qual_d[1];
      end

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_pad) begin
      if (rst_pad) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         cmd_sel_q    <= '0;
         cmd_qual_q   <= '0;
         strobe_q     <= '0;
         suppressed_q <= 1'b0;
         fault_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cmd_sel_q    <= cmd_sel_d;
         cmd_qual_q   <= cmd_qual_d;
         strobe_q     <= strobe_d;
         suppressed_q <= suppressed_d;
         fault_q      <= fault_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: occupancy and pointers alone define validity.
   always_ff @(posedge clk_pad) begin
      if (!rst_pad && push) begin
         mem_sel_q[wr_ptr_q]  <= sel_pad;
         mem_qual_q[wr_ptr_q] <= qual_pad[1:0];
      end
   end

   assign strobe_pad     = strobe_q;
   assign suppressed_pad = suppressed_q;
   assign fault_pad      = fault_q;
   assign out_valid_pad  = out_valid_q;
   assign busy_pad       = busy_q;
   assign count_pad      = count_q;

endmodule

// File: tb/tb_x2_seq_decoder.sv
// Testbench for x2_seq_decoder with default parameters (SEL_W=3, QUAL_W=7, DEPTH=4,
// HOLD_CYC=2). Reference model: the ordered list of accepted-but-undelivered commands.
// While busy, the held command is the oldest entry; FIFO occupancy is the list size minus
// the held one.
module tb_x2_seq_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] sel;
   logic [6:0] qual;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] strobe;
   logic       suppressed;
   logic       fault;
   logic       busy;
   logic [2:0] count;

   always #5 clk = ~clk;

   x2_seq_decoder #(
      .SEL_W   (3),
      .QUAL_W  (7),
      .DEPTH   (DEPTH),
      .HOLD_CYC(2)
   ) dut (
      .clk_pad       (clk),
      .rst_pad       (rst),
      .in_valid_pad  (in_valid),
      .in_ready_pad  (in_ready),
      .sel_pad       (sel),
      .qual_pad      (qual),
      .out_valid_pad (out_valid),
      .out_ready_pad (out_ready),
      .strobe_pad    (strobe),
      .suppressed_pad(suppressed),
      .fault_pad     (fault),
      .busy_pad      (busy),
      .count_pad     (count)
   );

   typedef struct packed {
      logic [2:0] sel;
      logic [6:0] qual;
   } cmd_t;

   cmd_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   bit   last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_strobe(input cmd_t c);
      logic [7:0] one;
      one = 8'h01;
      return c.qual[0] ? (one << c.sel) : 8'h00;
   endfunction

   // One clock: account handshakes in the model, then advance to 1ns after the edge.
   task automatic tick();
      cmd_t c;
      last_acc = 1'b0;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready) begin
            hs_cnt++;
            checks++;
            assert (exp_q.size() > 0)
            else begin
               errors++;
               $error("FAIL hs_unexpected: observed result with empty model, expected none");
            end
            if (exp_q.size() > 0) begin
               c = exp_q.pop_front();
               check("hs_strobe", strobe, exp_strobe(c));
               check("hs_suppressed", suppressed, !c.qual[0]);
               check("hs_fault", fault, (&c.sel) & c.qual[1]);
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            c.sel  = sel;
            c.qual = qual;
            exp_q.push_back(c);
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_state();
      int occ;
      int fifo_occ;
      occ = exp_q.size();
      if (busy === 1'b1) begin
         checks++;
         assert (occ > 0)
         else begin
            errors++;
            $error("FAIL st_busy_empty: observed busy with empty model, expected idle");
         end
         fifo_occ = (occ > 0) ? occ - 1 : 0;
         if (occ > 0) begin
            check("st_strobe", strobe, exp_strobe(exp_q[0]));
            check("st_suppressed", suppressed, !exp_q[0].qual[0]);
            check("st_fault", fault, (&exp_q[0].sel) & exp_q[0].qual[1]);
         end
      end else begin
         fifo_occ = occ;
         check("st_idle_strobe", strobe, 0);
         check("st_idle_valid", out_valid, 0);
         check("st_idle_flags", {suppressed, fault}, 0);
      end
      check("st_count", count, fifo_occ);
      check("st_in_ready", in_ready, fifo_occ < DEPTH);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() > 0 || busy === 1'b1) && n < 100) begin
         tick();
         check_state();
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int accepted;
      int n;
      int drops;
      int hs0;
      int vcnt;
      bit started;

      // Reset with a command offered during the reset edge
      rst       = 1'b1;
      in_valid  = 1'b1;
      sel       = 3'b101;
      qual      = 7'h01;
      out_ready = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_strobe", strobe, 0);
      check("rst_flags", {suppressed, fault, out_valid, busy}, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", count, 0);
      tick();
      check("rst_nothing_taken", {busy, count}, 0);

      // Single command sel=5, qual=1
      hs0      = hs_cnt;
      in_valid = 1'b1;
      sel      = 3'b101;
      qual     = 7'h01;
      tick();
      in_valid = 1'b0;
`ifndef X2_SEQ_BYPASS_EN
      check("single_fifo_count", count, 1);
      check("single_not_busy", busy, 0);
      tick();
`endif
      check("single_strobe", strobe, 8'h20);
      check("single_busy", busy, 1);
      check("single_hold_valid0", out_valid, 0);
      tick();
      check("single_hold_valid1", out_valid, 0);
      tick();
      check("single_present", out_valid, 1);
      check("single_present_strobe", strobe, 8'h20);
      tick();
      check("single_idle", {busy, out_valid}, 0);
      check("single_idle_strobe", strobe, 0);
      check("single_hs", hs_cnt - hs0, 1);

      // sel all-ones, enable low, fault-arm set
      in_valid = 1'b1;
      sel      = 3'b111;
      qual     = 7'h02;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         check_state();
         tick();
         n++;
      end
      check("fault_valid_seen", out_valid, 1);
      check("fault_strobe", strobe, 0);
      check("fault_suppressed", suppressed, 1);
      check("fault_fault", fault, 1);
      tick();
      check("fault_idle", busy, 0);

      // Backpressure: hold valid with out_ready low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepted  = 0;
      repeat (12) begin
         tick();
         if (last_acc) begin
            accepted++;
            sel  = 3'($urandom);
            qual = 7'($urandom);
         end
         check_state();
      end
      check("bp_accepted", accepted, 5);
      check("bp_count", count, 4);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_ready_back", in_ready, 1);
      check_state();
      drain("bp");

      // Back-to-back: three commands, busy must never drop between them
      hs0      = hs_cnt;
      drops    = 0;
      started  = 1'b0;
      accepted = 0;
      n        = 0;
      in_valid = 1'b1;
      sel      = 3'($urandom);
      qual     = 7'($urandom);
      while (accepted < 3 && n < 20) begin
         tick();
         if (busy === 1'b1) started = 1'b1;
         if (last_acc) begin
            accepted++;
            sel  = 3'($urandom);
            qual = 7'($urandom) | 7'h01;
         end
         check_state();
         n++;
      end
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         if (busy === 1'b1) started = 1'b1;
         else if (started) drops++;
         tick();
         check_state();
         n++;
      end
      check("b2b_no_bubble", drops, 0);
      check("b2b_handshakes", hs_cnt - hs0, 3);
      drain("b2b");

      // Mid-operation reset with two commands queued
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepted  = 0;
      n         = 0;
      while (accepted < 3 && n < 20) begin
         tick();
         if (last_acc) begin
            accepted++;
            sel  = 3'($urandom);
            qual = 7'($urandom) | 7'h01;
         end
         n++;
      end
      in_valid = 1'b0;
      check("mid_count2", count, 2);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_outs", {strobe, suppressed, fault, out_valid, busy}, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      vcnt = 0;
      repeat (10) begin
         if (out_valid === 1'b1) vcnt++;
         tick();
      end
      check("mid_never_presented", vcnt, 0);
      check("mid_stays_idle", busy, 0);

      // Randomised traffic against the model
      in_valid = 1'b0;
      repeat (400) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 9) < 6);
            sel      = 3'($urandom);
            qual     = 7'($urandom);
         end
         out_ready = 1'($urandom_range(0, 1));
         tick();
         check_state();
      end
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
